// File: rtl/reset_sequencer_pkg.sv
// Shared types and legal parameter ranges for the domain reset sequencer.
package reset_sequencer_pkg;

  // Sequencer states; the unused encoding 2'd3 recovers to SYNC.
  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int HOLD_CYCLES_MIN = 1;
  localparam int HOLD_CYCLES_MAX = 255;

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// Reset deassertion synchroniser: asserts asynchronously, releases after
// SYNC_STAGES clock edges with RST low.
module reset_sync_chain
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic sync_ok
);

  if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_stages
    $fatal(1, "reset_sync_chain: SYNC_STAGES=%0d outside legal range", SYNC_STAGES);
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // A constant 1 is shifted in; the last stage is the settled indication.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};

  // Chain register, cleared asynchronously by RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_ok = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Domain reset sequencer: immediate reset assertion on RST, synchronised and
// stretched release, plus a synchronous soft-reset request.
//
// Handshake note: there is no valid/ready pairing here; DONE is a single-cycle
// strobe aligned with the first cycle OUT_RST_N reads 1, and BUSY is a level
// that is high whenever the domain is not released.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ_RST,
  output logic OUT_RST_N,
  output logic OUT_RST,
  output logic BUSY,
  output logic DONE
);

  if ((HOLD_CYCLES < HOLD_CYCLES_MIN) || (HOLD_CYCLES > HOLD_CYCLES_MAX)) begin : g_bad_hold
    $fatal(1, "reset_sequencer: HOLD_CYCLES=%0d outside legal range", HOLD_CYCLES);
  end
  if ((CNT_W < 1) || ((CNT_W < 31) && ((2 ** CNT_W) <= HOLD_CYCLES))) begin : g_bad_cnt_w
    $fatal(1, "reset_sequencer: CNT_W=%0d too narrow for HOLD_CYCLES=%0d", CNT_W, HOLD_CYCLES);
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync_ok;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_rst_n_q, out_rst_n_d;
  logic             out_rst_q, out_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .sync_ok(sync_ok)
  );

  // Next-state, hold counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SYNC: begin
        cnt_d = '0;
        // The edge that leaves SYNC is counted as hold cycle 0, so the
        // release lands exactly HOLD_CYCLES edges after the chain settles.
        if (sync_ok) begin
          if (HOLD_LAST == '0) begin
            state_d = RUN;
          end else begin
            state_d = HOLD;
            cnt_d   = CNT_ONE;
          end
        end
      end
      HOLD: begin
        if (REQ_RST) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (REQ_RST) begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = SYNC;
        cnt_d   = '0;
      end
    endcase

    out_rst_n_d = (state_d == RUN);
    out_rst_d   = (state_d != RUN);
    busy_d      = (state_d != RUN);
    done_d      = (state_d == RUN) && (state_q != RUN);
  end

  // State, counter and output registers, all forced to reset values on RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      out_rst_n_q <= 1'b0;
      out_rst_q   <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_rst_n_q <= out_rst_n_d;
      out_rst_q   <= out_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign OUT_RST_N = out_rst_n_q;
  assign OUT_RST   = out_rst_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a driver issues edges and pushes the
// expected output vector; a monitor pops and compares on every falling edge.
module tb_reset_sequencer;

  localparam int SS = 2;
  localparam int HH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic req;
  logic out_rst_n, out_rst, busy, done;
  logic big_req;
  logic big_rst_n, big_rst, big_busy, big_done;

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES(SS),
    .HOLD_CYCLES(HH),
    .CNT_W      (8)
  ) u_dut (
    .CLK      (clk),
    .RST      (rst),
    .REQ_RST  (req),
    .OUT_RST_N(out_rst_n),
    .OUT_RST  (out_rst),
    .BUSY     (busy),
    .DONE     (done)
  );

  reset_sequencer #(
    .SYNC_STAGES(4),
    .HOLD_CYCLES(255),
    .CNT_W      (8)
  ) u_dut_big (
    .CLK      (clk),
    .RST      (rst),
    .REQ_RST  (big_req),
    .OUT_RST_N(big_rst_n),
    .OUT_RST  (big_rst),
    .BUSY     (big_busy),
    .DONE     (big_done)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];  // {OUT_RST_N, OUT_RST, BUSY, DONE}

  localparam logic [3:0] RESET_VEC = 4'b0110;

  task automatic check_vec(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got {rst_n,rst,busy,done}=%b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Release happens at a target edge number counted from reset release.
  // Initially that is SS+HH; a request sampled outside the synchroniser
  // phase pushes the target to HH edges after the requesting edge.
  int m_n;
  int m_target;
  bit m_prev;

  function automatic void model_reset();
    m_n      = 0;
    m_target = SS + HH;
    m_prev   = 1'b0;
  endfunction

  function automatic logic [3:0] model_edge(input bit r);
    bit o;
    bit d;
    m_n++;
    if ((m_n > SS + 1) && r) m_target = m_n + HH;
    o = (m_n >= m_target);
    d = o & ~m_prev;
    m_prev = o;
    return {o, ~o, ~o, d};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_vec("cycle", {out_rst_n, out_rst, busy, done}, e);
    end
  end

  // ---------------- driver ----------------
  // act: 0 plain edge, 1 release RST before the edge, 2 sub-cycle RST
  // glitch before the edge, 3 assert RST mid-cycle and keep it asserted.
  task automatic step(input bit r, input int act = 0);
    @(negedge clk);
    req = r;
    if (act == 1) rst = 1'b0;
    if (act == 2) begin
      #2 rst = 1'b1;
      #1 check_vec("glitch_async", {out_rst_n, out_rst, busy, done}, RESET_VEC);
      #1 rst = 1'b0;
      model_reset();
    end
    if (act == 3) begin
      #2 rst = 1'b1;
      #1 check_vec("async_assert", {out_rst_n, out_rst, busy, done}, RESET_VEC);
      model_reset();
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
      exp_q.push_back(RESET_VEC);
    end else begin
      exp_q.push_back(model_edge(r));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first;
    int done_cnt;
    int pick;
    rst     = 1'b1;
    req     = 1'b0;
    big_req = 1'b0;
    model_reset();
    #1;
    check_vec("reset_state", {out_rst_n, out_rst, busy, done}, RESET_VEC);
    check_vec("reset_state_big", {big_rst_n, big_rst, big_busy, big_done}, RESET_VEC);

    // power-on release after 5 cycles of reset
    repeat (5) step(0);
    step(0, 1);
    repeat (9) step(0);

    // single-cycle soft reset from RUN
    step(1);
    repeat (7) step(0);

    // hold extension: second request at hold count 2
    step(1);
    step(0);
    step(0);
    step(1);
    repeat (8) step(0);

    // async reset during HOLD, then full sequence again
    step(1);
    step(0);
    step(0, 3);
    step(0);
    step(0, 1);
    repeat (9) step(0);

    // sub-cycle glitch while running
    step(0, 2);
    repeat (9) step(0);

    // sticky request
    repeat (50) step(1);
    repeat (6) step(0);

    // randomized mix
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 99);
      if (pick < 3) begin
        step(0, 2);
      end else if (pick < 5) begin
        step(0, 3);
        repeat ($urandom_range(0, 3)) step(0);
        step(0, 1);
      end else begin
        step($urandom_range(0, 9) == 0);
      end
    end
    repeat (8) step(0);

    // wide configuration: release edge SYNC_STAGES+HOLD_CYCLES = 259
    step(0, 3);
    step(0);
    first    = -1;
    done_cnt = 0;
    for (int e = 1; e <= 265; e++) begin
      step(0, (e == 1) ? 1 : 0);
      #1;
      if (big_rst_n && (first < 0)) first = e;
      if (big_done) done_cnt++;
      if (big_rst !== ~big_rst_n) begin
        check_vec("big_rst_inverse", {big_rst_n, big_rst, 2'b00}, {big_rst_n, ~big_rst_n, 2'b00});
      end
    end
    check_int("big_release_edge", first, 259);
    check_int("big_done_count", done_cnt, 1);

    repeat (2) @(negedge clk);
    #1;
    check_int("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
